pkt_dispatch_sequencer: RTL and testbench
=========================================

Name: pkt_dispatch_sequencer

Overview:
- Sits between the packet filter and the node's compute units: MNI, KCH, QTU and reward.
- Buffers filtered packet events in a small FIFO. Each event is type plus destination-match flag.
- Sequences the downstream units one at a time with a start/done handshake, so only one unit works per packet stage.
- Replaces direct enable fan-out; adds ordering, back-pressure visibility and a per-stage watchdog.

Parameters:
- FIFO_DEPTH, 4, number of buffered packet events; power of 2, minimum 2.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles for a done before the packet is aborted.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset; synchronous, active-high (asserted = 1), sampled on the rising edge of clk.
- newpkt  in  1  one-cycle pulse: a new filtered packet is present.
- fPktType  in  3  packet type, valid with newpkt. 000 HB, 001 CHE, 010 INV, 011 DATA; others unsupported.
- destMatch  in  1  destination ID equals myNodeID, valid with newpkt.
- done_bus  in  4  unit done pulses: [0] MNI, [1] KCH, [2] QTU, [3] reward.
- start_bus  out  4  unit start pulses, same bit mapping; at most one bit high in any cycle.
- iAmDestination  out  1  one-cycle pulse: a DATA packet has terminated at this node.
- busy  out  1  high whenever the FSM is not in IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- fifo_full  out  1  fifo_count == FIFO_DEPTH.
- err_timeout  out  1  sticky watchdog error flag.
- drop_count  out  CNT_W  dropped-event counter (STATS_EN only).
- timeout_count  out  CNT_W  watchdog-abort counter (STATS_EN only).

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, watchdog counter 0. Reset mid-operation discards the FIFO contents and any in-flight packet immediately; no start pulse is issued in the cycle after reset.
- Push:
  - newpkt is sampled at the edge and the event is written to the FIFO tail.
  - If fifo_full is true before that edge, the event is dropped, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves fifo_count unchanged.
- Dispatch plan, decoded from the FIFO head at pop:
  - HB: MNI, then reward.
  - CHE with destMatch=1: KCH only. CHE with destMatch=0: discard, no starts issued.
  - INV: QTU, then reward.
  - DATA with destMatch=1: one iAmDestination pulse, no starts issued. DATA with destMatch=0: QTU (forward decision) only.
  - Types 100-111: discard.
- FSM states: IDLE, ISSUE, WAIT, NEXT.
  - IDLE: if the FIFO is not empty, pop the head and latch its plan.
    - If the plan has no stages, pulse iAmDestination where applicable and stay in IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: assert exactly one start_bus bit for one cycle, clear the watchdog counter, go to WAIT.
  - WAIT: watch only the done bit of the active unit; other done bits are ignored.
    - Done arrives: if a second stage is pending go to NEXT, else go to IDLE.
    - A done pulse during the ISSUE cycle is ignored.
    - The watchdog counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES, abandon the rest of the packet, set err_timeout and go to IDLE.
  - NEXT: load stage 2, go to ISSUE.
- Latency: newpkt at edge N into an empty, idle block → pop at N+1 → start pulse during the cycle after N+1. Minimum of 3 cycles between start pulses of consecutive single-stage packets when done returns 1 cycle after start.
- err_timeout: sticky; cleared only by reset.
- Counters saturate at 2^CNT_W-1 and never wrap.

Optional Feature:
- Macro: PKT_DISPATCH_STATS_EN.
- Defined:
  - drop_count increments on each FIFO-full drop and each discarded or unsupported-type pop.
  - timeout_count increments on each watchdog abort.
- Undefined: both ports are present but tied to 0; the counter logic is removed.

Test Plan:
- Reset, then HB (000) at cycle 5 with done returned 2 cycles after each start → start_bus=0001 then 1000; busy falls 1 cycle after the reward done; err_timeout=0.
- CHE destMatch=0, then CHE destMatch=1 → no start for the first; start_bus=0010 for the second. drop_count=1 under STATS_EN.
- DATA destMatch=1 → one iAmDestination pulse, start_bus stays 0. DATA destMatch=0 → start_bus=0100.
- Hold all done bits low, send INV (010) → start 0100, then abort after 64 WAIT cycles; err_timeout=1; next queued packet dispatches normally.
- Stall done, push 6 HBs back-to-back → fifo_count=4, fifo_full=1, 1-2 drops depending on pops (drop_count matches); the remaining 4 packets are dispatched in order.
- Assert nrst while in WAIT with 3 events queued → next cycle: FSM in IDLE, fifo_count=0, all outputs 0; no later start pulses.

Source files
------------

// File: rtl/pkt_dispatch_sequencer.sv
// pkt_dispatch_sequencer: buffers filtered packet events in a small FIFO and
// runs the compute units (MNI, KCH, QTU, reward) one at a time through a
// start/done handshake, with a per-stage watchdog.
// Optional statistics counters: define PKT_DISPATCH_STATS_EN to build them;
// otherwise drop_count and timeout_count are tied to zero.
module pkt_dispatch_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        newpkt,
  input  logic [2:0]                  fPktType,
  input  logic                        destMatch,
  input  logic [3:0]                  done_bus,
  output logic [3:0]                  start_bus,
  output logic                        iAmDestination,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        err_timeout,
  output logic [CNT_W-1:0]            drop_count,
  output logic [CNT_W-1:0]            timeout_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] UNIT_MNI = 4'b0001;
  localparam logic [3:0] UNIT_KCH = 4'b0010;
  localparam logic [3:0] UNIT_QTU = 4'b0100;
  localparam logic [3:0] UNIT_RWD = 4'b1000;

  localparam logic [2:0] TYPE_HB   = 3'b000;
  localparam logic [2:0] TYPE_CHE  = 3'b001;
  localparam logic [2:0] TYPE_INV  = 3'b010;
  localparam logic [2:0] TYPE_DATA = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT
  } state_t;

  state_t         state;

  logic [3:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic [3:0]     head;
  logic [3:0]     head_first;
  logic [3:0]     head_second;
  logic           head_iam;

  logic [3:0]     cur_bus;
  logic [3:0]     pend_bus;
  logic [WDW-1:0] wd_cnt;

  logic           push;
  logic           pop;
  logic           done_hit;
  logic           abort;

  assign fifo_count = count;
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign busy       = (state != IDLE);

  // A full FIFO rejects the new event even if the head leaves on the same edge.
  assign push     = newpkt && !fifo_full;
  assign pop      = (state == IDLE) && (count != '0);
  assign done_hit = |(done_bus & cur_bus);
  assign abort    = (state == WAIT) && !done_hit &&
                    (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  // Decode the head event into up to two unit stages plus a local-delivery flag.
  always_comb begin
    head        = mem[rd_ptr];
    head_first  = '0;
    head_second = '0;
    head_iam    = 1'b0;
    case (head[3:1])
      TYPE_HB: begin
        head_first  = UNIT_MNI;
        head_second = UNIT_RWD;
      end
      TYPE_CHE: begin
        if (head[0]) head_first = UNIT_KCH;
      end
      TYPE_INV: begin
        head_first  = UNIT_QTU;
        head_second = UNIT_RWD;
      end
      TYPE_DATA: begin
        if (head[0]) head_iam = 1'b1;
        else         head_first = UNIT_QTU;
      end
      default: ;
    endcase
  end

  // Event storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {fPktType, destMatch};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Sequencer: pops one event, issues its stages in order and guards each wait.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state          <= IDLE;
      start_bus      <= '0;
      iAmDestination <= 1'b0;
      cur_bus        <= '0;
      pend_bus       <= '0;
      wd_cnt         <= '0;
      err_timeout    <= 1'b0;
    end else begin
      start_bus      <= '0;
      iAmDestination <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_first != '0) begin
              start_bus <= head_first;
              cur_bus   <= head_first;
              pend_bus  <= head_second;
              state     <= ISSUE;
            end else begin
              iAmDestination <= head_iam;
            end
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (done_hit) begin
            state <= (pend_bus != '0) ? NEXT : IDLE;
          end else if (abort) begin
            err_timeout <= 1'b1;
            pend_bus    <= '0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        NEXT: begin
          start_bus <= pend_bus;
          cur_bus   <= pend_bus;
          pend_bus  <= '0;
          state     <= ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PKT_DISPATCH_STATS_EN
  logic           drop_full;
  logic           discard_pop;
  logic [CNT_W:0] drop_sum;

  assign drop_full   = newpkt && fifo_full;
  assign discard_pop = pop && (head[3] || ((head[3:1] == TYPE_CHE) && !head[0]));
  assign drop_sum    = {1'b0, drop_count} + {{CNT_W{1'b0}}, drop_full}
                     + {{CNT_W{1'b0}}, discard_pop};

  // Saturating statistics: a full-FIFO drop and a discarded pop may share an edge.
  always_ff @(posedge clk) begin
    if (nrst) begin
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (drop_sum > {1'b0, {CNT_W{1'b1}}}) drop_count <= '1;
      else                                  drop_count <= drop_sum[CNT_W-1:0];
      if (abort && (timeout_count != '1)) timeout_count <= timeout_count + CNT_W'(1);
    end
  end
`else
  assign drop_count    = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_pkt_dispatch_sequencer.sv
// tb_pkt_dispatch_sequencer: directed and randomized stimulus for
// pkt_dispatch_sequencer, checked every cycle against a queue-based
// reference model of the dispatch rules.
module tb_pkt_dispatch_sequencer;

  localparam int DEPTH   = 4;
  localparam int TMO     = 64;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             nrst = 1'b1;
  logic             newpkt = 1'b0;
  logic [2:0]       fPktType = 3'b000;
  logic             destMatch = 1'b0;
  logic [3:0]       done_bus = 4'b0000;
  logic [3:0]       start_bus;
  logic             iAmDestination;
  logic             busy;
  logic [2:0]       fifo_count;
  logic             fifo_full;
  logic             err_timeout;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] timeout_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending events, remaining unit indices of the packet in
  // flight, and the age of the current stage in cycles since its start pulse
  // (-1 = gap cycle between two stages).
  logic [3:0] mq[$];
  int         units[$];
  int         age = 0;
  bit         m_iam = 0;
  bit         m_err = 0;
  int         m_drop = 0;
  int         m_tmo = 0;

  // Automatic done responder driven from the model's expected start pulses.
  int resp_delay = 0;
  int done_at [4] = '{-1, -1, -1, -1};

  pkt_dispatch_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .newpkt(newpkt),
    .fPktType(fPktType),
    .destMatch(destMatch),
    .done_bus(done_bus),
    .start_bus(start_bus),
    .iAmDestination(iAmDestination),
    .busy(busy),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full),
    .err_timeout(err_timeout),
    .drop_count(drop_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input bit rst, input bit np, input logic [2:0] t,
                           input bit m, input logic [3:0] d);
    bit         full_pre;
    logic [3:0] e;
    if (rst) begin
      mq.delete();
      units.delete();
      age    = 0;
      m_iam  = 0;
      m_err  = 0;
      m_drop = 0;
      m_tmo  = 0;
      return;
    end
    full_pre = (mq.size() == DEPTH);
    m_iam    = 0;
    if (units.size() == 0) begin
      if (mq.size() > 0) begin
        e   = mq.pop_front();
        age = 0;
        case (e[3:1])
          3'd0: begin units.push_back(0); units.push_back(3); end
          3'd1: if (e[0]) units.push_back(1); else m_drop++;
          3'd2: begin units.push_back(2); units.push_back(3); end
          3'd3: if (e[0]) m_iam = 1; else units.push_back(2);
          default: m_drop++;
        endcase
      end
    end else if (age == -1) begin
      age = 0;
    end else if (age == 0) begin
      age = 1;
    end else if (d[units[0]]) begin
      void'(units.pop_front());
      age = -1;
    end else if (age == TMO) begin
      units.delete();
      m_err = 1;
      m_tmo++;
    end else begin
      age++;
    end
    if (np) begin
      if (full_pre) m_drop++;
      else          mq.push_back({t, m});
    end
    if (m_drop > CNT_MAX) m_drop = CNT_MAX;
    if (m_tmo > CNT_MAX)  m_tmo  = CNT_MAX;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] expStart();
    logic [3:0] s;
    s = 4'b0000;
    if (units.size() > 0 && age == 0) s[units[0]] = 1'b1;
    return s;
  endfunction

  // Compares every DUT output against the model for the current cycle.
  task automatic checkOutput();
    int exp_drop;
    int exp_tmo;
`ifdef PKT_DISPATCH_STATS_EN
    exp_drop = m_drop;
    exp_tmo  = m_tmo;
`else
    exp_drop = 0;
    exp_tmo  = 0;
`endif
    chk("start_bus", start_bus, expStart());
    chk("iAmDestination", iAmDestination, m_iam);
    chk("busy", busy, (units.size() > 0));
    chk("fifo_count", fifo_count, mq.size());
    chk("fifo_full", fifo_full, (mq.size() == DEPTH));
    chk("err_timeout", err_timeout, m_err);
    chk("drop_count", drop_count, exp_drop);
    chk("timeout_count", timeout_count, exp_tmo);
  endtask

  // Drives one cycle of inputs, advances one clock and checks the result.
  task automatic applyStimulus(input bit rst, input bit np, input logic [2:0] t,
                               input bit m, input logic [3:0] d);
    logic [3:0] dv;
    logic [3:0] es;
    dv = d;
    for (int u = 0; u < 4; u++) if (done_at[u] == cyc) dv[u] = 1'b1;
    nrst      = rst;
    newpkt    = np;
    fPktType  = t;
    destMatch = m;
    done_bus  = dv;
    @(posedge clk);
    cyc++;
    modelStep(rst, np, t, m, dv);
    #1;
    checkOutput();
    es = expStart();
    if (resp_delay > 0)
      for (int u = 0; u < 4; u++) if (es[u]) done_at[u] = cyc + resp_delay;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 3'd0, 0, 4'b0000);
  endtask

  initial begin
    $display("[TB] reset and HB dispatch");
    applyStimulus(1, 0, 3'd0, 0, 4'b0000);
    applyStimulus(1, 0, 3'd0, 0, 4'b0000);
    idle(3);
    resp_delay = 2;
    applyStimulus(0, 1, 3'b000, 0, 4'b0000);
    idle(12);
    chk("hb_err_clear", err_timeout, 0);
    chk("hb_idle", busy, 0);

    $display("[TB] CHE discard then CHE to KCH");
    resp_delay = 1;
    applyStimulus(0, 1, 3'b001, 0, 4'b0000);
    applyStimulus(0, 1, 3'b001, 1, 4'b0000);
    idle(8);

    $display("[TB] DATA local then DATA forward");
    applyStimulus(0, 1, 3'b011, 1, 4'b0000);
    applyStimulus(0, 1, 3'b011, 0, 4'b0000);
    idle(8);

    $display("[TB] INV watchdog abort then HB");
    resp_delay = 0;
    applyStimulus(0, 1, 3'b010, 0, 4'b0000);
    applyStimulus(0, 1, 3'b000, 0, 4'b0000);
    resp_delay = 1;
    idle(80);
    chk("inv_err_sticky", err_timeout, 1);
    idle(10);

    $display("[TB] FIFO overflow with stalled units");
    resp_delay = 0;
    repeat (6) applyStimulus(0, 1, 3'b000, 0, 4'b0000);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_full", fifo_full, 1);
    resp_delay = 1;
    applyStimulus(0, 0, 3'd0, 0, 4'b0001);
    idle(60);
    chk("ovf_drained", fifo_count, 0);

    $display("[TB] reset during WAIT with events queued");
    resp_delay = 0;
    repeat (4) applyStimulus(0, 1, 3'b000, 0, 4'b0000);
    idle(3);
    applyStimulus(1, 0, 3'd0, 0, 4'b0000);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    idle(10);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1200; i++) begin
      bit         np;
      bit         rst;
      logic [3:0] d;
      if (i % 100 == 0)
        resp_delay = (i >= 600 && i < 900) ? 0 : int'($urandom_range(1, 4));
      d = 4'b0000;
      if (i >= 600 && i < 900) begin
        np = 1'b1;
        if ($urandom_range(0, 63) == 0) d = 4'($urandom);
      end else begin
        np = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0) d = 4'($urandom);
      end
      rst = (i == 1000);
      applyStimulus(rst, np, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), d);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
